// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: CPU-priority arbiter for one single-port sync memory with a read-only debug port
// and a starvation limit that forces a debug grant.
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_gnt_o,
    output logic          cpu_rvalid_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          dbg_req_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic          dbg_gnt_o,
    output logic          dbg_rvalid_o,
    output logic [DW-1:0] dbg_rdata_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [3:0]    starve_cnt_o
);
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_DBG = 2'd2} owner_e;
    localparam logic [3:0] LIM = 4'(STARVE_LIM);
    owner_e        owner_q, owner_d;
    logic [3:0]    starve_q, starve_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;
    logic          starved;
    assign starved      = starve_q >= LIM;
    assign starve_cnt_o = starve_q;
    assign mem_wdata_o  = cpu_wdata_i;
    // CPU also wins when starved but the debug request has just dropped, so no cycle is wasted
    always_comb begin
        dbg_gnt_o    = rstn && dbg_req_i && (!cpu_req_i || starved);
        cpu_gnt_o    = rstn && cpu_req_i && !dbg_gnt_o;
        mem_we_o     = cpu_gnt_o && cpu_we_i;
        mem_addr_o   = cpu_gnt_o ? cpu_addr_i : dbg_gnt_o ? dbg_addr_i : addr_q;
        starve_d     = (dbg_req_i && !dbg_gnt_o) ? ((starve_q == 4'hf) ? starve_q : starve_q + 4'd1) : 4'd0;
        owner_d      = (cpu_gnt_o && !cpu_we_i) ? OWN_CPU : dbg_gnt_o ? OWN_DBG : OWN_NONE;
        cpu_rvalid_o = rstn && (owner_q == OWN_CPU);
        dbg_rvalid_o = rstn && (owner_q == OWN_DBG);
        cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
        dbg_rdata_o  = dbg_rvalid_o ? mem_rdata_i : dbg_rdata_q;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            owner_q     <= OWN_NONE;
            starve_q    <= 4'd0;
            addr_q      <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            addr_q      <= mem_addr_o;
            cpu_rdata_q <= cpu_rdata_o;
            dbg_rdata_q <= dbg_rdata_o;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven directed vectors against a behavioural sync memory,
// plus a hand-written starvation sequence.
module tb_mem_port_arbiter;
    logic        clk, rstn;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  starve_cnt;
    logic [31:0] mem [256];
    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter dut (
        .clk(clk), .rstn(rstn),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
        .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_gnt_o(dbg_gnt),
        .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .starve_cnt_o(starve_cnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic rstn, creq, cwe; logic [7:0] caddr; logic [31:0] cwd; logic dreq; logic [7:0] daddr;
        logic cg, dg, we; logic [7:0] maddr; logic crv; logic [31:0] crd; logic drv; logic [31:0] drd; logic [3:0] sc;
    } vec_t;
    vec_t v [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cr, input logic cw, input logic [7:0] ca,
                         input logic [31:0] cd, input logic dr, input logic [7:0] da);
        rstn = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; dbg_req = dr; dbg_addr = da;
    endtask

    initial begin
        int ncpu;
        bit got_dbg;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h11] = 32'h11111111;
        mem[8'h20] = 32'h20202020;
        mem[8'h30] = 32'h30303030;
        v[0]  = '{0,1,1,8'h55,32'hFFFF0000,1,8'h66, 0,0,0,8'h00,0,32'h0,0,32'h0,4'd0};
        v[1]  = '{1,1,0,8'h10,32'h0,0,8'h00, 1,0,0,8'h10,0,32'h0,0,32'h0,4'd0};
        v[2]  = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h10,1,32'hDEADBEEF,0,32'h0,4'd0};
        v[3]  = '{1,0,0,8'h00,32'h0,1,8'h20, 0,1,0,8'h20,0,32'hDEADBEEF,0,32'h0,4'd0};
        v[4]  = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h20,0,32'hDEADBEEF,1,32'h20202020,4'd0};
        v[5]  = '{1,1,1,8'h03,32'h5A5A5A5A,0,8'h00, 1,0,1,8'h03,0,32'hDEADBEEF,0,32'h20202020,4'd0};
        v[6]  = '{1,1,0,8'h03,32'h0,0,8'h00, 1,0,0,8'h03,0,32'hDEADBEEF,0,32'h20202020,4'd0};
        v[7]  = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h03,1,32'h5A5A5A5A,0,32'h20202020,4'd0};
        v[8]  = '{1,1,0,8'h11,32'h0,0,8'h00, 1,0,0,8'h11,0,32'h5A5A5A5A,0,32'h20202020,4'd0};
        v[9]  = '{1,0,0,8'h00,32'h0,1,8'h30, 0,1,0,8'h30,1,32'h11111111,0,32'h20202020,4'd0};
        v[10] = '{1,1,0,8'h10,32'h0,0,8'h00, 1,0,0,8'h10,0,32'h11111111,1,32'h30303030,4'd0};
        v[11] = '{1,0,0,8'h00,32'h0,1,8'h20, 0,1,0,8'h20,1,32'hDEADBEEF,0,32'h30303030,4'd0};
        v[12] = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h20,0,32'hDEADBEEF,1,32'h20202020,4'd0};
        v[13] = '{1,1,0,8'h10,32'h0,1,8'h30, 1,0,0,8'h10,0,32'hDEADBEEF,0,32'h20202020,4'd0};
        v[14] = '{1,1,0,8'h10,32'h0,1,8'h30, 1,0,0,8'h10,1,32'hDEADBEEF,0,32'h20202020,4'd1};
        v[15] = '{1,1,0,8'h10,32'h0,1,8'h30, 1,0,0,8'h10,1,32'hDEADBEEF,0,32'h20202020,4'd2};
        v[16] = '{1,1,0,8'h10,32'h0,1,8'h30, 1,0,0,8'h10,1,32'hDEADBEEF,0,32'h20202020,4'd3};
        v[17] = '{1,1,0,8'h10,32'h0,1,8'h30, 0,1,0,8'h30,1,32'hDEADBEEF,0,32'h20202020,4'd4};
        v[18] = '{1,1,0,8'h10,32'h0,1,8'h30, 1,0,0,8'h10,0,32'hDEADBEEF,1,32'h30303030,4'd0};
        v[19] = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h10,1,32'hDEADBEEF,0,32'h30303030,4'd1};
        v[20] = '{1,0,0,8'h00,32'h0,1,8'h30, 0,1,0,8'h30,0,32'hDEADBEEF,0,32'h30303030,4'd0};
        v[21] = '{0,1,1,8'h55,32'h0,1,8'h66, 0,0,0,8'h30,0,32'hDEADBEEF,0,32'h30303030,4'd0};
        v[22] = '{0,1,1,8'h55,32'h0,1,8'h66, 0,0,0,8'h00,0,32'h0,0,32'h0,4'd0};
        v[23] = '{1,0,0,8'h00,32'h0,0,8'h00, 0,0,0,8'h00,0,32'h0,0,32'h0,4'd0};

        drive(0, 0, 0, 8'h0, 32'h0, 0, 8'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            drive(v[i].rstn, v[i].creq, v[i].cwe, v[i].caddr, v[i].cwd, v[i].dreq, v[i].daddr);
            #1;
            chk($sformatf("v%0d cpu_gnt", i), 32'(cpu_gnt), 32'(v[i].cg));
            chk($sformatf("v%0d dbg_gnt", i), 32'(dbg_gnt), 32'(v[i].dg));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v[i].we));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(v[i].maddr));
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(v[i].crv));
            chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, v[i].crd);
            chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(v[i].drv));
            chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, v[i].drd);
            chk($sformatf("v%0d starve_cnt", i), 32'(starve_cnt), 32'(v[i].sc));
            if (v[i].we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v[i].cwd);
            @(negedge clk);
        end

        // Both requesters held: expect exactly four CPU grants, then the forced debug grant.
        ncpu = 0;
        got_dbg = 0;
        drive(1, 1, 0, 8'h11, 32'h0, 1, 8'h20);
        for (int c = 0; c < 10 && !got_dbg; c++) begin
            #1;
            chk($sformatf("seq c%0d grant mutex", c), 32'(cpu_gnt & dbg_gnt), 32'h0);
            if (dbg_gnt) got_dbg = 1;
            else if (cpu_gnt) ncpu++;
            @(negedge clk);
        end
        chk("seq dbg grant within bound", 32'(got_dbg), 32'h1);
        chk("seq cpu grants before dbg", 32'(ncpu), 32'd4);
        drive(1, 0, 0, 8'h00, 32'h0, 0, 8'h00);
        #1;
        chk("seq starve_cnt cleared", 32'(starve_cnt), 32'h0);
        chk("seq dbg_rvalid", 32'(dbg_rvalid), 32'h1);
        chk("seq dbg_rdata", dbg_rdata, 32'h20202020);
        chk("seq cpu_rvalid", 32'(cpu_rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
